eprom_prog_seq: RTL and testbench
=================================

# eprom_prog_seq

Hardware sequencer for the intelligent (fast-pulse) programming algorithm of 27xx-class EPROMs such as the M2764A. It sits between the microcontroller register file and the ZIF pin drivers. For one byte it drives address, data, E, G and P, issues repeated 1 ms P pulses with read-back verify, then applies the final overprogram pulse. The microcontroller only loads address and data, starts the sequence and polls status, instead of timing each pulse itself.

## Interface
Parameters:
- ADDR_W, 13, DUT address width
- DATA_W, 8, DUT data width
- TICK_DIV, 12000, osc cycles per 1 ms program pulse unit (12 MHz)
- SETUP_CYC, 24, address/data/E setup before P falls (2 us)
- READ_CYC, 12, G-low settle before verify sample (1 us)
- MAX_TRIES, 25, verify-failed pulses before giving up
- OVERPROG_MULT, 3, overprogram pulse length = OVERPROG_MULT × tries ms

Ports:
- osc  in  1  12 MHz clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; latches cfg_addr/cfg_data
- abort  in  1  single-cycle cancel
- cfg_addr  in  ADDR_W  target address
- cfg_data  in  DATA_W  byte to program
- dut_q  in  DATA_W  ZIF Q pins, read back during verify
- busy  out  1  sequence running
- done  out  1  one-cycle completion pulse
- fail  out  1  result of last sequence; sticky until next accepted start
- tries  out  5  pulses used in last or current sequence
- dut_addr  out  ADDR_W  to A pins
- dut_data  out  DATA_W  to Q pins
- dut_data_oe  out  1  1 = FPGA drives Q pins
- dut_E, dut_G, dut_P  out  1 each  active-low chip controls

## Operation
- Reset values: busy=0, done=0, fail=0, tries=0, dut_addr=0, dut_data=0, dut_data_oe=0, dut_E=1, dut_G=1, dut_P=1. Reset during a pulse releases P at once, asynchronously.
- States: IDLE → SETUP → PULSE → RECOVER → VERIFY → (PULSE | OVERPROG | FINISH) → IDLE.
- IDLE: start latches addr/data, sets tries=0 and fail=0, and moves to SETUP.
- SETUP: E=0, G=1, oe=1, data driven; hold SETUP_CYC cycles.
- PULSE: P=0 for TICK_DIV cycles; tries increments on entry.
- RECOVER: P=1, then oe=0 one cycle later; hold 2 cycles total.
- VERIFY: G=0 for READ_CYC cycles; sample dut_q on the last cycle, then G=1.
  - Match: go to OVERPROG.
  - Mismatch and tries<MAX_TRIES: re-enter via SETUP with oe=1.
  - Mismatch and tries==MAX_TRIES: fail=1, go to FINISH.
- OVERPROG: same as SETUP then PULSE, but P=0 for OVERPROG_MULT×tries×TICK_DIV cycles. No verify afterwards. Go to FINISH.
- FINISH: E=1, G=1, P=1, oe=0. done=1 for one cycle, busy=0 on the same edge, return to IDLE.
- Abort in any non-IDLE state: next edge forces P=1, G=1, E=1, oe=0, fail=1, done pulse, IDLE.
  - Abort in IDLE is ignored.
  - start together with abort in IDLE: nothing happens.
- start while busy is ignored; the latched address and data never change mid-sequence.
- Unsigned arithmetic throughout. Overprogram length uses a 7-bit ms counter (max 75) plus a TICK_DIV cycle counter; no overflow at maximum parameters.

## Timing
- start sampled high at edge N: busy=1 and dut_E=0 at N+1. dut_P falls at N+1+SETUP_CYC.
- Each try is TICK_DIV+2+READ_CYC cycles, plus SETUP_CYC before every retry pulse.
- Outputs are registered, with no combinational path from inputs to outputs.
- P, G and oe never change on the same edge as each other:
  - P rises before oe drops.
  - oe is 0 while G=0.
- done and the busy falling edge coincide. fail and tries are valid while done=1 and hold until the next start.

## Structure
- Shared include eprom_prog_pkg: state encoding (3 bits), default timing constants, tries width.
- One sub-module, prog_timer: loadable down-counter with a zero flag. It serves setup, read and ms ticking, and is also reusable by later EPROM sequencers.

## Test plan
Bench parameters: TICK_DIV=10, SETUP_CYC=2, READ_CYC=2, MAX_TRIES=4.
- Model programs on 1st pulse; start addr=0x1ABC data=0x5A → tries=1, one P low of 10 cycles, overprogram P low 30 cycles, fail=0, done once, dut_addr=0x1ABC throughout.
- Model matches after 3rd pulse → tries=3, overprogram 90 cycles, fail=0.
- Model never matches (returns 0xFF, data 0x00) → exactly 4 pulses, no overprogram, fail=1, tries=4.
- abort 5 cycles into the 2nd PULSE → P=1 next edge, done pulse, fail=1, busy=0; a new start succeeds.
- rst_n low mid-PULSE → P=1 immediately without a clock, all outputs at reset values; start during busy and start+abort in IDLE both produce no activity.

Source files
------------

// File: rtl/eprom_prog_pkg.sv
// rtl/eprom_prog_pkg.sv - shared state encoding and timing defaults for EPROM sequencers
package eprom_prog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_PULSE    = 3'd2,
    ST_RECOVER  = 3'd3,
    ST_VERIFY   = 3'd4,
    ST_OVERPROG = 3'd5,
    ST_FINISH   = 3'd6
  } prog_state_e;

  localparam int TRIES_W = 5;
  localparam int MS_W    = 7;
  localparam int TMR_W   = 16;

  localparam int DEF_TICK_DIV      = 12000;
  localparam int DEF_SETUP_CYC     = 24;
  localparam int DEF_READ_CYC      = 12;
  localparam int DEF_MAX_TRIES     = 25;
  localparam int DEF_OVERPROG_MULT = 3;

endpackage

// File: rtl/prog_timer.sv
// rtl/prog_timer.sv - loadable down-counter with zero flag for sequencer phase timing
module prog_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/eprom_prog_seq.sv
// rtl/eprom_prog_seq.sv - fast-pulse EPROM byte programming sequencer
module eprom_prog_seq
  import eprom_prog_pkg::*;
#(
  parameter int ADDR_W        = 13,
  parameter int DATA_W        = 8,
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int SETUP_CYC     = DEF_SETUP_CYC,
  parameter int READ_CYC      = DEF_READ_CYC,
  parameter int MAX_TRIES     = DEF_MAX_TRIES,
  parameter int OVERPROG_MULT = DEF_OVERPROG_MULT
) (
  input  logic               osc,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [DATA_W-1:0]  cfg_data,
  input  logic [DATA_W-1:0]  dut_q,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [TRIES_W-1:0] tries,
  output logic [ADDR_W-1:0]  dut_addr,
  output logic [DATA_W-1:0]  dut_data,
  output logic               dut_data_oe,
  output logic               dut_E,
  output logic               dut_G,
  output logic               dut_P
);

  prog_state_e        state_q;
  logic               busy_q, done_q, fail_q, oe_q, e_q, g_q, p_q, ovp_pulse_q;
  logic [TRIES_W-1:0] tries_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic [MS_W-1:0]    ms_q;
  logic [MS_W-1:0]    ovp_ms;
  logic               tmr_load, tmr_zero;
  logic [TMR_W-1:0]   tmr_val;

  // Phase lengths are loaded as N-1 so that the state lasts exactly N cycles.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        tmr_load = start && !abort;
        tmr_val  = TMR_W'(SETUP_CYC - 1);
      end
      ST_SETUP, ST_OVERPROG: begin
        tmr_load = tmr_zero;
        tmr_val  = TMR_W'(TICK_DIV - 1);
      end
      ST_PULSE: begin
        tmr_load = tmr_zero;
        tmr_val  = TMR_W'(1);
      end
      ST_RECOVER: begin
        tmr_load = tmr_zero;
        tmr_val  = TMR_W'(READ_CYC - 1);
      end
      ST_VERIFY: begin
        tmr_load = tmr_zero;
        tmr_val  = TMR_W'(SETUP_CYC - 1);
      end
      default: ;
    endcase
  end

  prog_timer #(.W(TMR_W)) u_timer (
    .clk      (osc),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign ovp_ms = MS_W'(OVERPROG_MULT * int'(tries_q)) - MS_W'(1);

  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      tries_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      oe_q        <= 1'b0;
      e_q         <= 1'b1;
      g_q         <= 1'b1;
      p_q         <= 1'b1;
      ms_q        <= '0;
      ovp_pulse_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != ST_IDLE && abort) begin
        state_q     <= ST_IDLE;
        busy_q      <= 1'b0;
        done_q      <= 1'b1;
        fail_q      <= 1'b1;
        oe_q        <= 1'b0;
        e_q         <= 1'b1;
        g_q         <= 1'b1;
        p_q         <= 1'b1;
        ovp_pulse_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start && !abort) begin
              addr_q  <= cfg_addr;
              data_q  <= cfg_data;
              tries_q <= '0;
              fail_q  <= 1'b0;
              busy_q  <= 1'b1;
              e_q     <= 1'b0;
              oe_q    <= 1'b1;
              state_q <= ST_SETUP;
            end
          end
          ST_SETUP: begin
            // On a retry G has just risen, so oe returns one edge later.
            oe_q <= 1'b1;
            if (tmr_zero) begin
              p_q     <= 1'b0;
              tries_q <= tries_q + TRIES_W'(1);
              state_q <= ST_PULSE;
            end
          end
          ST_PULSE: begin
            if (tmr_zero) begin
              p_q     <= 1'b1;
              state_q <= ST_RECOVER;
            end
          end
          ST_RECOVER: begin
            oe_q <= 1'b0;
            if (tmr_zero) begin
              g_q     <= 1'b0;
              state_q <= ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            if (tmr_zero) begin
              g_q <= 1'b1;
              if (dut_q == data_q) begin
                ovp_pulse_q <= 1'b0;
                state_q     <= ST_OVERPROG;
              end else if (tries_q < TRIES_W'(MAX_TRIES)) begin
                state_q <= ST_SETUP;
              end else begin
                fail_q  <= 1'b1;
                state_q <= ST_FINISH;
              end
            end
          end
          ST_OVERPROG: begin
            if (!ovp_pulse_q) begin
              oe_q <= 1'b1;
              if (tmr_zero) begin
                p_q         <= 1'b0;
                ovp_pulse_q <= 1'b1;
                ms_q        <= ovp_ms;
              end
            end else if (tmr_zero) begin
              if (ms_q == '0) begin
                p_q         <= 1'b1;
                ovp_pulse_q <= 1'b0;
                state_q     <= ST_FINISH;
              end else begin
                ms_q <= ms_q - MS_W'(1);
              end
            end
          end
          ST_FINISH: begin
            oe_q    <= 1'b0;
            e_q     <= 1'b1;
            g_q     <= 1'b1;
            p_q     <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign tries       = tries_q;
  assign dut_addr    = addr_q;
  assign dut_data    = data_q;
  assign dut_data_oe = oe_q;
  assign dut_E       = e_q;
  assign dut_G       = g_q;
  assign dut_P       = p_q;

endmodule

// File: tb/tb_eprom_prog_seq.sv
// tb/tb_eprom_prog_seq.sv - scoreboard bench for eprom_prog_seq with a pulse-counting EPROM model
module tb_eprom_prog_seq;

  localparam int ADDR_W        = 13;
  localparam int DATA_W        = 8;
  localparam int TICK_DIV      = 10;
  localparam int SETUP_CYC     = 2;
  localparam int READ_CYC      = 2;
  localparam int MAX_TRIES     = 4;
  localparam int OVERPROG_MULT = 3;

  logic              osc = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [DATA_W-1:0] cfg_data = '0;
  logic [DATA_W-1:0] dut_q;
  logic              busy, done, fail, dut_data_oe, dut_E, dut_G, dut_P;
  logic [4:0]        tries;
  logic [ADDR_W-1:0] dut_addr;
  logic [DATA_W-1:0] dut_data;

  typedef struct {
    logic       fail;
    logic [4:0] tries;
    int         npulse;
    int         first_len;
    int         last_len;
  } exp_t;

  exp_t              sb_q[$];
  int                checks = 0;
  int                errors = 0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [DATA_W-1:0] prog_byte = '0;
  int                need_pulses = 1;
  int                fall_cnt = 0;
  int                cur_len = 0;
  int                npulse = 0;
  int                first_len = 0;
  int                last_len = 0;
  logic              prev_p = 1'b1;
  logic              prev_done = 1'b0;
  int                n;

  // EPROM model: reads back the programmed byte once enough P pulses were seen.
  assign dut_q = (fall_cnt >= need_pulses) ? prog_byte : 8'hFF;

  eprom_prog_seq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TICK_DIV(TICK_DIV), .SETUP_CYC(SETUP_CYC),
    .READ_CYC(READ_CYC), .MAX_TRIES(MAX_TRIES), .OVERPROG_MULT(OVERPROG_MULT)
  ) dut (
    .osc(osc), .rst_n(rst_n), .start(start), .abort(abort), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .dut_q(dut_q), .busy(busy), .done(done), .fail(fail),
    .tries(tries), .dut_addr(dut_addr), .dut_data(dut_data), .dut_data_oe(dut_data_oe),
    .dut_E(dut_E), .dut_G(dut_G), .dut_P(dut_P)
  );

  initial forever #5 osc = ~osc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: tracks P pulses and pops the scoreboard on every done pulse.
  initial forever begin
    exp_t e;
    @(negedge osc);
    if (!rst_n) begin
      fall_cnt = 0; cur_len = 0; npulse = 0; first_len = 0; last_len = 0;
      prev_p = 1'b1; prev_done = 1'b0;
    end else begin
      if (!dut_P) begin
        if (prev_p) begin fall_cnt++; npulse++; end
        cur_len++;
      end else if (!prev_p) begin
        if (npulse == 1) first_len = cur_len;
        last_len = cur_len;
        cur_len  = 0;
      end
      prev_p = dut_P;
      if (busy) chk("addr_hold", dut_addr, exp_addr);
      if (!dut_G) chk("oe_low_while_g_low", dut_data_oe, 0);
      if (prev_done) chk("done_one_cycle", done, 0);
      prev_done = done;
      if (done) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          chk("result_fail", fail, e.fail);
          chk("result_tries", tries, e.tries);
          chk("pulse_count", npulse, e.npulse);
          chk("first_pulse_len", first_len, e.first_len);
          chk("last_pulse_len", last_len, e.last_len);
          chk("busy_low_at_done", busy, 0);
          chk("pins_released_at_done", {dut_E, dut_G, dut_P, dut_data_oe}, 4'b1110);
        end
        fall_cnt = 0; npulse = 0; first_len = 0; last_len = 0; cur_len = 0;
      end
    end
  end

  task automatic issue(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input int need, input bit push, input exp_t e);
    @(negedge osc);
    cfg_addr = a; cfg_data = d; prog_byte = d; need_pulses = need; exp_addr = a;
    if (push) sb_q.push_back(e);
    start = 1'b1;
    @(negedge osc);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int k = 0;
    while (busy && k < maxc) begin @(negedge osc); k++; end
    chk("sequence_ends_in_budget", busy, 0);
  endtask

  task automatic wait_p(input logic lvl, input int maxc);
    int k = 0;
    while (dut_P !== lvl && k < maxc) begin @(negedge osc); k++; end
    chk("p_level_reached", dut_P, lvl);
  endtask

  initial begin
    repeat (2) @(negedge osc);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_tries", tries, 0);
    chk("rst_addr", dut_addr, 0);
    chk("rst_data", dut_data, 0);
    chk("rst_oe_E_G_P", {dut_data_oe, dut_E, dut_G, dut_P}, 4'b0111);
    rst_n = 1'b1;

    // Programs on the first pulse; also checks start-to-P latency.
    issue(13'h1ABC, 8'h5A, 1, 1'b1, '{1'b0, 5'd1, 2, 10, 30});
    chk("busy_after_start", busy, 1);
    chk("E_after_start", dut_E, 0);
    chk("oe_after_start", dut_data_oe, 1);
    chk("data_driven", dut_data, 8'h5A);
    n = 1;
    while (dut_P && n < 20) begin @(negedge osc); n++; end
    chk("setup_latency", n, 1 + SETUP_CYC);
    wait_idle(500);

    // Matches after the third pulse; a start mid-sequence must be ignored.
    issue(13'h0F0F, 8'hC3, 3, 1'b1, '{1'b0, 5'd3, 4, 10, 90});
    wait_p(1'b0, 50);
    n = 0;
    do begin @(negedge osc); n++; end while (!dut_P && n < 100);
    while (dut_P && n < 100) begin @(negedge osc); n++; end
    chk("retry_period", n, TICK_DIV + 2 + READ_CYC + SETUP_CYC);
    cfg_addr = 13'h0123; cfg_data = 8'h00; start = 1'b1;
    @(negedge osc);
    start = 1'b0;
    wait_idle(1000);

    // Never verifies: exactly MAX_TRIES pulses, no overprogram.
    issue(13'h1555, 8'h00, 99, 1'b1, '{1'b1, 5'd4, 4, 10, 10});
    wait_idle(1000);

    // Abort five cycles into the second pulse, then a clean restart.
    issue(13'h0A0A, 8'h3C, 99, 1'b1, '{1'b1, 5'd2, 2, 10, 5});
    wait_p(1'b0, 50);
    wait_p(1'b1, 50);
    wait_p(1'b0, 50);
    repeat (4) @(negedge osc);
    abort = 1'b1;
    @(negedge osc);
    abort = 1'b0;
    chk("abort_P_high", dut_P, 1);
    chk("abort_done", done, 1);
    chk("abort_busy_low", busy, 0);
    issue(13'h0A0A, 8'h3C, 1, 1'b1, '{1'b0, 5'd1, 2, 10, 30});
    wait_idle(500);

    // start together with abort in IDLE does nothing.
    @(negedge osc);
    start = 1'b1; abort = 1'b1;
    @(negedge osc);
    start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge osc);
    chk("start_abort_idle", {busy, dut_E, dut_P}, 3'b011);

    // Asynchronous reset in the middle of a pulse.
    issue(13'h1FFF, 8'h81, 1, 1'b0, '{1'b0, 5'd0, 0, 0, 0});
    wait_p(1'b0, 50);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_P", dut_P, 1);
    chk("async_rst_state", {busy, done, fail, dut_data_oe, dut_E, dut_G}, 6'b000011);
    chk("async_rst_tries", tries, 0);
    chk("async_rst_addr_data", {dut_addr, dut_data}, 0);
    @(negedge osc);
    rst_n = 1'b1;
    repeat (5) @(negedge osc);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
